// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO multiply control stage.
package hilo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic RD_LO = 1'b0;
  localparam logic RD_HI = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/hilo_mpy_ctrl.sv
// HI/LO register stage for an external combinational signed multiplier.
// The operand pair is registered at launch and held for MPY_LAT cycles so
// the multiplier output can settle before the product lands in HI/LO.
module hilo_mpy_ctrl
  import hilo_pkg::*;
#(
  parameter int W       = 32,
  parameter int MPY_LAT = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  output logic [W-1:0]   a_q,
  output logic [W-1:0]   b_q,
  input  logic [2*W-1:0] prod_in,
  input  logic           mthi,
  input  logic           mtlo,
  input  logic [W-1:0]   wr_data,
  input  logic           rd_sel,
  output logic [W-1:0]   rd_data,
  output logic [W-1:0]   hi,
  output logic [W-1:0]   lo,
  output logic           busy,
  output logic           done
);

  // Counter load value: the launch edge itself counts as the first settle
  // cycle, so the capture edge is the one where the counter reaches zero.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MPY_LAT - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             launch;
  logic             capture;

  // State register; reset drops any in-flight operation back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the launch/capture strobes used by the datapath.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          launch     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          capture    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, settle counter, HI/LO update and done pulse. A launch in
  // IDLE takes priority over mthi/mtlo, and moves are locked out while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      cnt  <= '0;
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= capture;
      if (launch) begin
        a_q <= op_a;
        b_q <= op_b;
        cnt <= CNT_INIT;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (capture) begin
        hi <= prod_in[2*W-1:W];
        lo <= prod_in[W-1:0];
      end else if (state == IDLE && !start) begin
        if (mthi) begin
          hi <= wr_data;
        end
        if (mtlo) begin
          lo <= wr_data;
        end
      end
    end
  end

  assign busy    = (state == WAIT);
  assign rd_data = (rd_sel == RD_HI) ? hi : lo;

endmodule

// File: tb/tb_hilo_mpy_ctrl.sv
// Directed bench for hilo_mpy_ctrl with an in-bench signed multiplier and a
// queue of expected {hi,lo} products checked at each done pulse.
module tb_hilo_mpy_ctrl;
  import hilo_pkg::*;

  localparam int W       = 32;
  localparam int MPY_LAT = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [2*W-1:0] prod_in;
  logic           mthi;
  logic           mtlo;
  logic [W-1:0]   wr_data;
  logic           rd_sel;
  logic [W-1:0]   rd_data;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;
  logic           busy;
  logic           done;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] sb[$];

  hilo_mpy_ctrl #(.W(W), .MPY_LAT(MPY_LAT)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .a_q     (a_q),
    .b_q     (b_q),
    .prod_in (prod_in),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .wr_data (wr_data),
    .rd_sel  (rd_sel),
    .rd_data (rd_data),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done)
  );

  // External signed multiplier: sign-extend both operands, keep 2W bits.
  assign prod_in = {{W{a_q[W-1]}}, a_q} * {{W{b_q[W-1]}}, b_q};

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [2*W-1:0] obs,
                              input logic [2*W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    sb.push_back(exp);
    step();
    start = 1'b0;
  endtask

  // Count busy cycles until done shows up, then compare HI/LO to the
  // oldest queued product.
  task automatic wait_done(input string tag, input int exp_busy);
    int nb    = 0;
    int guard = 0;
    logic [2*W-1:0] e;
    while (done !== 1'b1 && guard < 40) begin
      if (busy === 1'b1) nb++;
      step();
      guard++;
    end
    check_output({tag, "_seen_done"}, 64'(done), 64'(1));
    check_output({tag, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
    if (sb.size() == 0) begin
      check_output({tag, "_sb_empty"}, 64'(1), 64'(0));
    end else begin
      e = sb.pop_front();
      check_output({tag, "_hilo"}, {hi, lo}, e);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    mthi = 1'b0; mtlo = 1'b0; wr_data = '0; rd_sel = RD_LO;
    step(); step();
    reset = 1'b0;

    // Load HI, then reset must clear it.
    mthi = 1'b1; wr_data = 32'h0000_1234;
    step();
    mthi = 1'b0;
    check_output("pre_reset_hi", 64'(hi), 64'h1234);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_output("rst_hi", 64'(hi), 64'h0);
    check_output("rst_lo", 64'(lo), 64'h0);
    check_output("rst_busy", 64'(busy), 64'h0);
    check_output("rst_done", 64'(done), 64'h0);
    check_output("rst_a_q", 64'(a_q), 64'h0);

    // -1 * 1
    launch(32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF);
    check_output("m1_busy_at_T", 64'(busy), 64'h1);
    wait_done("m1", MPY_LAT);
    step();
    check_output("m1_done_fall", 64'(done), 64'h0);

    // min*min; operand change and mthi during WAIT are ignored
    launch(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    op_a = 32'h1234_5678;
    mthi = 1'b1; wr_data = 32'hDEAD_BEEF;
    step();
    check_output("m2_a_q_hold", 64'(a_q), 64'h8000_0000);
    check_output("m2_hi_locked", 64'(hi), 64'hFFFF_FFFF);
    check_output("m2_rd_busy", 64'(rd_data), 64'hFFFF_FFFF);
    wait_done("m2", MPY_LAT - 1);
    mthi = 1'b0;
    step();
    check_output("m2_done_fall", 64'(done), 64'h0);

    // moves in IDLE and HI read path
    mthi = 1'b1; wr_data = 32'hDEAD_BEEF;
    step();
    mthi = 1'b0;
    check_output("mthi_hi", 64'(hi), 64'hDEAD_BEEF);
    rd_sel = RD_HI;
    #1;
    check_output("rd_hi", 64'(rd_data), 64'hDEAD_BEEF);
    rd_sel = RD_LO;
    #1;
    check_output("rd_lo", 64'(rd_data), 64'h0);
    mthi = 1'b1; mtlo = 1'b1; wr_data = 32'h5;
    step();
    mthi = 1'b0; mtlo = 1'b0;
    check_output("both_hi", 64'(hi), 64'h5);
    check_output("both_lo", 64'(lo), 64'h5);

    // start wins over mtlo; start in WAIT is ignored
    mtlo = 1'b1; wr_data = 32'h0000_AAAA;
    launch(32'd3, 32'd4, 64'd12);
    mtlo = 1'b0;
    check_output("drop_mtlo_lo", 64'(lo), 64'h5);
    start = 1'b1; op_a = 32'd7; op_b = 32'd9;
    step();
    start = 1'b0;
    check_output("restart_a_q", 64'(a_q), 64'd3);
    check_output("restart_b_q", 64'(b_q), 64'd4);
    wait_done("m3", MPY_LAT - 1);
    step();
    check_output("m3_idle", 64'(busy), 64'h0);

    // reset at T+1 aborts without a done pulse
    op_a = 32'd5; op_b = 32'd6; start = 1'b1;
    step();
    start = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_output("abort_busy", 64'(busy), 64'h0);
    check_output("abort_hilo", {hi, lo}, 64'h0);
    check_output("abort_done", 64'(done), 64'h0);
    step();
    check_output("abort_done_late", 64'(done), 64'h0);

    // back-to-back: relaunch in the done cycle
    launch(32'd2, 32'd3, 64'd6);
    wait_done("m4", MPY_LAT);
    launch(32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
    check_output("b2b_done_fall", 64'(done), 64'h0);
    check_output("b2b_busy", 64'(busy), 64'h1);
    wait_done("m5", MPY_LAT);

    check_output("sb_drained", 64'(sb.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_mpy_ctrl.md
Name: hilo_mpy_ctrl

Overview:
- Sequential HI/LO register stage that sits directly downstream of the datapath's combinational 32x32 signed multiplier.
- Launches an operation by registering the operand pair that drives the multiplier.
- Holds that pair stable for a configurable multicycle settle window, then captures the 64-bit product into HI (upper) and LO (lower).
- Services mthi/mtlo writes and mfhi/mflo reads; exports busy so the pipeline stalls on HI/LO hazards.

Parameters:
- W, 32, operand width; HI and LO are each W bits; product is 2*W.
- MPY_LAT, 2, settle cycles between operand launch and product capture; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  mult request; sampled only in IDLE.
- op_a  in  W  multiplicand from register file.
- op_b  in  W  multiplier from register file.
- a_q  out  W  registered operand A, drives multiplier input A.
- b_q  out  W  registered operand B, drives multiplier input B.
- prod_in  in  2*W  signed product returned by the multiplier.
- mthi  in  1  write wr_data to HI.
- mtlo  in  1  write wr_data to LO.
- wr_data  in  W  write data for mthi/mtlo.
- rd_sel  in  1  0 selects LO, 1 selects HI.
- rd_data  out  W  combinational read of the selected register.
- hi  out  W  HI register.
- lo  out  W  LO register.
- busy  out  1  high while a mult is in flight.
- done  out  1  one-cycle pulse following product capture.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, a_q=b_q=0, hi=lo=0, cnt=0, busy=0, done=0.
- Reset asserted mid-operation aborts the operation: no capture occurs, done stays 0, and the block is in IDLE on the following cycle.
- FSM states: IDLE and WAIT. busy = (state==WAIT), decoded from registered state.
- IDLE, start=1 at edge T:
  - a_q<=op_a, b_q<=op_b, cnt<=MPY_LAT-1, state<=WAIT.
  - Any mthi/mtlo in the same cycle is dropped (start wins).
- WAIT:
  - a_q/b_q are held constant.
  - Each edge with cnt!=0 decrements cnt.
  - The edge with cnt==0 captures hi<=prod_in[2W-1:W] and lo<=prod_in[W-1:0], sets state<=IDLE, and sets done<=1.
  - Capture therefore occurs at edge T+MPY_LAT. busy is high for exactly MPY_LAT cycles. done is high for the single cycle after capture.
- done clears on the next edge unless a new capture occurs on that edge.
- start while in WAIT is ignored: no relaunch and no change to cnt or operands.
- mthi/mtlo in IDLE (start=0): the selected register(s) take wr_data at the edge. Both asserted together write wr_data to both.
- mthi/mtlo while busy are ignored; HI/LO are unchanged until capture.
- rd_data = rd_sel ? hi : lo, combinational. While busy it returns the pre-operation value; the consumer must stall on busy.
- Arithmetic: no sign manipulation in this block. prod_in is taken verbatim as a two's-complement 2W-bit value. The signed result is the upstream multiplier's responsibility.
- Back-to-back operation: start may be asserted in the cycle done is high (state is IDLE). That relaunch proceeds normally, and done falls on the next edge.

Decomposition:
- Package hilo_pkg holds:
  - state enum (IDLE, WAIT);
  - RD_LO=0 and RD_HI=1 constants;
  - counter width CNT_W=4.
- No sub-module. The multiplier stays external so it can be swapped for a pipelined version. The bench instantiates the existing signed multiplier between a_q/b_q and prod_in.

Test Plan:
- Reset with 0x1234 loaded via mthi -> hi=lo=0, busy=0, done=0 one cycle after reset.
- op_a=0xFFFFFFFF (-1), op_b=0x00000001, start (MPY_LAT=2) -> busy high for 2 cycles; at edge T+2, hi=0xFFFFFFFF and lo=0xFFFFFFFF; done pulses once.
- op_a=op_b=0x80000000, start -> hi=0x40000000, lo=0x00000000. Changing op_a during WAIT does not alter a_q or the result.
- mthi=1, wr_data=0xDEADBEEF while busy -> hi unchanged, then takes the product at capture. The same write in IDLE -> hi=0xDEADBEEF, rd_sel=1 reads 0xDEADBEEF. mthi+mtlo together with 0x5 -> hi=lo=5.
- start and mtlo in the same IDLE cycle -> mult launches and the mtlo write is dropped. start asserted again mid-WAIT -> ignored, capture still at T+MPY_LAT.
- reset asserted at T+1 of a mult -> next cycle IDLE, hi/lo=0, no done pulse. Relaunch with start in the done cycle -> second product captured MPY_LAT edges later.
